tuner_cmd_seq: RTL and testbench
================================

TUNER_CMD_SEQ -- requirements
Module: tuner_cmd_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum number of cycles spent waiting for a PHY DONE per command.
REQ-002 SHALL have parameter MAX_RETRY, default 3, the number of full INIT-SEARCH-LOCK retries allowed before failing.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1, a single-cycle request to begin the lock sequence.
REQ-006 SHALL have port i_stop, input, 1, a single-cycle request to release the lock (UNLOCK).
REQ-007 SHALL have port o_cmd, output, 5, the command to the PHY (tuner_cmd_e).
REQ-008 SHALL have port o_cmd_valid, output, 1, meaning o_cmd is offered.
REQ-009 SHALL have port i_cmd_ready, input, 1, PHY accept; a transfer occurs when o_cmd_valid and i_cmd_ready are both high.
REQ-010 SHALL have port i_phy_state, input, 5, the PHY status (tuner_state_e: IDLE/ACTIVE/DONE/ERROR).
REQ-011 SHALL have ports o_busy, o_locked and o_error, output, 1 each: sequence in progress, lock achieved, and sequence failed.
REQ-012 SHALL have port o_err_code, output, 2, a tuner_seq_err_e value.
REQ-013 SHALL have port o_retry_cnt, output, $clog2(MAX_RETRY+1), the number of retries consumed.

Function
REQ-014 SHALL implement FSM states SEQ_IDLE, SEQ_ISSUE, SEQ_WAIT, SEQ_LOCKED, SEQ_UNLOCK_ISSUE, SEQ_UNLOCK_WAIT and SEQ_FAIL.
REQ-015 SHALL track the phase register in the order INIT->SEARCH->LOCK; o_cmd equals the phase in SEQ_ISSUE and UNLOCK in SEQ_UNLOCK_ISSUE.
REQ-016 SHALL, on i_start in SEQ_IDLE or SEQ_FAIL, set phase=INIT, retry=0 and err=NONE, and enter SEQ_ISSUE next cycle.
REQ-017 SHALL assert o_cmd_valid exactly in the ISSUE states and hold o_cmd stable until transfer; on transfer, go to the matching WAIT state next cycle.
REQ-018 SHALL, on entering a WAIT state, clear the timeout counter and a disarm flag.
REQ-019 SHALL set the arm flag when i_phy_state!=DONE; DONE counts only while armed, so a stale DONE is ignored.
REQ-020 SHALL, in SEQ_WAIT on armed DONE, advance INIT->SEARCH or SEARCH->LOCK and go to SEQ_ISSUE, or go from LOCK to SEQ_LOCKED.
REQ-021 SHALL, in SEQ_WAIT on ERROR (err=PHY) or counter==TIMEOUT_CYCLES-1 without DONE (err=TIMEOUT), retry: if retry<MAX_RETRY then retry+1, phase=INIT, SEQ_ISSUE; else SEQ_FAIL.
REQ-022 SHALL give DONE priority over timeout when both occur in the same cycle.
REQ-023 SHALL make o_err_code hold the most recent failure cause; it clears only on i_start or rst.
REQ-024 SHALL drive o_locked high only in SEQ_LOCKED, o_busy high in every state except SEQ_IDLE, SEQ_LOCKED and SEQ_FAIL, and o_error high only in SEQ_FAIL.
REQ-025 SHALL, on i_stop in SEQ_WAIT or SEQ_LOCKED, enter SEQ_UNLOCK_ISSUE next cycle.
REQ-026 SHALL, on i_stop in SEQ_ISSUE, latch a pending stop, complete the current transfer, then enter SEQ_UNLOCK_ISSUE.
REQ-027 SHALL, in SEQ_UNLOCK_WAIT on armed DONE, go to SEQ_IDLE; on ERROR or timeout, go to SEQ_FAIL with the corresponding err, with no retry.
REQ-028 SHALL ignore i_stop in SEQ_IDLE; in SEQ_FAIL, i_stop returns to SEQ_IDLE and keeps o_err_code.
REQ-029 SHALL give i_stop priority when i_start and i_stop are high in the same cycle; i_start is ignored in states other than SEQ_IDLE and SEQ_FAIL.
REQ-030 SHALL make the timeout counter saturate and never wrap.

Reset
REQ-031 SHALL, on rst, set state=SEQ_IDLE, phase=INIT, o_cmd=INIT, o_cmd_valid=0, o_busy=0, o_locked=0, o_error=0, o_err_code=SEQ_ERR_NONE, o_retry_cnt=0, counter=0, arm=0 and pending stop=0.
REQ-032 SHALL give rst priority over all inputs and abandon any handshake in progress; o_cmd_valid is low in the cycle after rst.

Structure
REQ-033 SHALL define tuner_seq_state_e and tuner_seq_err_e {SEQ_ERR_NONE, SEQ_ERR_PHY, SEQ_ERR_TIMEOUT} in tuner_phy_pkg, alongside tuner_cmd_e and tuner_state_e.
REQ-034 SHALL implement the timeout counter with arm flag as sub-module tuner_seq_timer (inputs clear, enable; output expired); the FSM stays in tuner_cmd_seq.

Verification
REQ-035 SHALL cover the happy path: TIMEOUT_CYCLES=16, ready always 1, PHY returns ACTIVE then DONE 3 cycles after each command -> commands INIT, SEARCH, LOCK issued in order, then o_locked=1 and o_busy=0.
REQ-036 SHALL cover backpressure: i_cmd_ready low for 5 cycles during INIT -> o_cmd_valid stays 1 and o_cmd stays INIT for all 5 cycles, with exactly one transfer.
REQ-037 SHALL cover PHY error: ERROR during SEARCH on the first attempt -> o_retry_cnt=1, the next command is INIT, and lock then completes with o_err_code=PHY.
REQ-038 SHALL cover timeout exhaustion: MAX_RETRY=2 and PHY never DONE -> SEQ_FAIL after 3x16 wait cycles (plus handshake cycles), o_error=1, o_err_code=TIMEOUT, o_retry_cnt=2.
REQ-039 SHALL cover the stale-DONE case: i_phy_state held at DONE across a transfer -> no advance until a non-DONE then DONE is seen.
REQ-040 SHALL cover stop and reset: i_stop in SEQ_LOCKED -> UNLOCK issued, then DONE -> SEQ_IDLE and o_locked=0; rst asserted in SEQ_WAIT -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY command sequencer: PHY commands, PHY status,
// sequencer FSM states and failure codes.
package tuner_phy_pkg;

    typedef enum logic [4:0] {
        CMD_NOP    = 5'd0,
        CMD_INIT   = 5'd1,
        CMD_SEARCH = 5'd2,
        CMD_LOCK   = 5'd3,
        CMD_UNLOCK = 5'd4
    } tuner_cmd_e;

    typedef enum logic [4:0] {
        PHY_IDLE   = 5'd0,
        PHY_ACTIVE = 5'd1,
        PHY_DONE   = 5'd2,
        PHY_ERROR  = 5'd3
    } tuner_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_LOCKED,
        SEQ_UNLOCK_ISSUE,
        SEQ_UNLOCK_WAIT,
        SEQ_FAIL
    } tuner_seq_state_e;

    typedef enum logic [1:0] {
        SEQ_ERR_NONE    = 2'd0,
        SEQ_ERR_PHY     = 2'd1,
        SEQ_ERR_TIMEOUT = 2'd2
    } tuner_seq_err_e;

    // Lock phases run INIT -> SEARCH -> LOCK; anything else restarts at INIT.
    function automatic tuner_cmd_e next_phase(input tuner_cmd_e phase);
        case (phase)
            CMD_INIT:   return CMD_SEARCH;
            CMD_SEARCH: return CMD_LOCK;
            default:    return CMD_INIT;
        endcase
    endfunction

endpackage

// File: rtl/tuner_seq_timer.sv
// Per-command wait timer: saturating cycle counter plus an arm flag that is set
// once the PHY reports anything other than DONE, so a stale DONE is ignored.
module tuner_seq_timer
    import tuner_phy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  tuner_state_e phy_state,
    output logic         expired,
    output logic         armed
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          arm_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
            arm_q <= 1'b0;
        end else if (enable) begin
            // Hold at the last count instead of wrapping back to zero.
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (phy_state != PHY_DONE) begin
                arm_q <= 1'b1;
            end
        end
    end

    assign expired = enable && (cnt_q == LAST);
    assign armed   = arm_q;

endmodule

// File: rtl/tuner_cmd_seq.sv
// Tuner lock sequencer: issues INIT, SEARCH, LOCK to the PHY with retry on
// error/timeout, and UNLOCK on request. All outputs are registered.
module tuner_cmd_seq
    import tuner_phy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic                               i_stop,
    output tuner_cmd_e                         o_cmd,
    output logic                               o_cmd_valid,
    input  logic                               i_cmd_ready,
    input  tuner_state_e                       i_phy_state,
    output logic                               o_busy,
    output logic                               o_locked,
    output logic                               o_error,
    output tuner_seq_err_e                     o_err_code,
    output logic [$clog2(MAX_RETRY+1)-1:0]     o_retry_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    tuner_seq_state_e state_q, state_d;
    tuner_cmd_e       phase_q, phase_d;
    tuner_cmd_e       cmd_q, cmd_d;
    tuner_seq_err_e   err_q, err_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             stop_pend_q, stop_pend_d;
    logic             valid_q, busy_q, locked_q, error_q;

    logic in_wait, xfer, done_ok, phy_err, tmr_expired, tmr_armed;

    assign in_wait = (state_q == SEQ_WAIT) || (state_q == SEQ_UNLOCK_WAIT);
    assign xfer    = valid_q && i_cmd_ready;
    assign done_ok = tmr_armed && (i_phy_state == PHY_DONE);
    assign phy_err = (i_phy_state == PHY_ERROR);

    // Holding clear outside the WAIT states gives a fresh count and disarmed
    // flag on the first WAIT cycle.
    tuner_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!in_wait),
        .enable   (in_wait),
        .phy_state(i_phy_state),
        .expired  (tmr_expired),
        .armed    (tmr_armed)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        err_d       = err_q;
        retry_d     = retry_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            SEQ_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d     = SEQ_ISSUE;
                    phase_d     = CMD_INIT;
                    retry_d     = '0;
                    err_d       = SEQ_ERR_NONE;
                    stop_pend_d = 1'b0;
                end
            end
            SEQ_FAIL: begin
                if (i_stop) begin
                    state_d = SEQ_IDLE;
                end else if (i_start) begin
                    state_d     = SEQ_ISSUE;
                    phase_d     = CMD_INIT;
                    retry_d     = '0;
                    err_d       = SEQ_ERR_NONE;
                    stop_pend_d = 1'b0;
                end
            end
            SEQ_ISSUE: begin
                // A stop seen while offering a command waits for the handshake.
                if (xfer) begin
                    stop_pend_d = 1'b0;
                    state_d     = (stop_pend_q || i_stop) ? SEQ_UNLOCK_ISSUE : SEQ_WAIT;
                end else if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            SEQ_WAIT: begin
                if (i_stop) begin
                    state_d = SEQ_UNLOCK_ISSUE;
                end else if (done_ok) begin
                    if (phase_q == CMD_LOCK) begin
                        state_d = SEQ_LOCKED;
                    end else begin
                        phase_d = next_phase(phase_q);
                        state_d = SEQ_ISSUE;
                    end
                end else if (phy_err || tmr_expired) begin
                    err_d = phy_err ? SEQ_ERR_PHY : SEQ_ERR_TIMEOUT;
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        phase_d = CMD_INIT;
                        state_d = SEQ_ISSUE;
                    end else begin
                        state_d = SEQ_FAIL;
                    end
                end
            end
            SEQ_LOCKED: begin
                if (i_stop) begin
                    state_d = SEQ_UNLOCK_ISSUE;
                end
            end
            SEQ_UNLOCK_ISSUE: begin
                if (xfer) begin
                    state_d = SEQ_UNLOCK_WAIT;
                end
            end
            SEQ_UNLOCK_WAIT: begin
                if (done_ok) begin
                    state_d = SEQ_IDLE;
                end else if (phy_err) begin
                    err_d   = SEQ_ERR_PHY;
                    state_d = SEQ_FAIL;
                end else if (tmr_expired) begin
                    err_d   = SEQ_ERR_TIMEOUT;
                    state_d = SEQ_FAIL;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_d = cmd_q;
        if (state_d == SEQ_UNLOCK_ISSUE) begin
            cmd_d = CMD_UNLOCK;
        end else if (state_d == SEQ_ISSUE) begin
            cmd_d = phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            phase_q     <= CMD_INIT;
            cmd_q       <= CMD_INIT;
            err_q       <= SEQ_ERR_NONE;
            retry_q     <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= (state_d == SEQ_ISSUE) || (state_d == SEQ_UNLOCK_ISSUE);
            busy_q      <= !((state_d == SEQ_IDLE) || (state_d == SEQ_LOCKED) ||
                             (state_d == SEQ_FAIL));
            locked_q    <= (state_d == SEQ_LOCKED);
            error_q     <= (state_d == SEQ_FAIL);
        end
    end

    assign o_cmd       = cmd_q;
    assign o_cmd_valid = valid_q;
    assign o_busy      = busy_q;
    assign o_locked    = locked_q;
    assign o_error     = error_q;
    assign o_err_code  = err_q;
    assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_tuner_cmd_seq.sv
// Directed bench for tuner_cmd_seq: a cycle table for lock + unlock, then
// hand sequences for backpressure, retry, timeout, stale DONE, stop and reset.
module tb_tuner_cmd_seq;
    import tuner_phy_pkg::*;

    logic           clk;
    logic           rst;
    logic           i_start;
    logic           i_stop;
    tuner_cmd_e     o_cmd;
    logic           o_cmd_valid;
    logic           i_cmd_ready;
    tuner_state_e   i_phy_state;
    logic           o_busy;
    logic           o_locked;
    logic           o_error;
    tuner_seq_err_e o_err_code;
    logic [1:0]     o_retry_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int xfers  = 0;

    tuner_cmd_seq #(
        .TIMEOUT_CYCLES(16),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .o_cmd      (o_cmd),
        .o_cmd_valid(o_cmd_valid),
        .i_cmd_ready(i_cmd_ready),
        .i_phy_state(i_phy_state),
        .o_busy     (o_busy),
        .o_locked   (o_locked),
        .o_error    (o_error),
        .o_err_code (o_err_code),
        .o_retry_cnt(o_retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         st;
        logic         sp;
        logic         rdy;
        tuner_state_e ph;
        logic         valid;
        tuner_cmd_e   cmd;
        logic         busy;
        logic         locked;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic st, input logic sp, input logic rdy,
                                input tuner_state_e ph, input logic valid,
                                input tuner_cmd_e cmd, input logic busy,
                                input logic locked);
        vec_t v;
        v.st = st; v.sp = sp; v.rdy = rdy; v.ph = ph;
        v.valid = valid; v.cmd = cmd; v.busy = busy; v.locked = locked;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs, count a handshake if one will happen, clock once, settle.
    task automatic step(input logic st, input logic sp, input logic rdy,
                        input tuner_state_e ph);
        i_start     = st;
        i_stop      = sp;
        i_cmd_ready = rdy;
        i_phy_state = ph;
        if (o_cmd_valid && rdy) xfers++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, PHY_IDLE);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  o_cmd_valid, 0);
        chk({tag, "_cmd"},    o_cmd,       CMD_INIT);
        chk({tag, "_busy"},   o_busy,      0);
        chk({tag, "_locked"}, o_locked,    0);
        chk({tag, "_error"},  o_error,     0);
        chk({tag, "_err"},    o_err_code,  SEQ_ERR_NONE);
        chk({tag, "_retry"},  o_retry_cnt, 0);
    endtask

    // Expect command c on offer, then accept it and let the PHY finish it.
    task automatic do_cmd(input string tag, input tuner_cmd_e c);
        chk({tag, "_valid"}, o_cmd_valid, 1);
        chk({tag, "_cmd"},   o_cmd,       c);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        step(1'b0, 1'b0, 1'b1, PHY_DONE);
    endtask

    initial begin
        int base;
        int steps;

        i_start = 1'b0; i_stop = 1'b0; i_cmd_ready = 1'b0; i_phy_state = PHY_IDLE;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, PHY_IDLE);
        step(1'b0, 1'b0, 1'b0, PHY_IDLE);
        rst = 1'b0;
        chk_reset_vals("por");

        // Full lock, then stop from LOCKED and UNLOCK back to idle.
        vecs[0]  = mk(1, 0, 1, PHY_IDLE,   1, CMD_INIT,   1, 0);
        vecs[1]  = mk(0, 0, 1, PHY_IDLE,   0, CMD_INIT,   1, 0);
        vecs[2]  = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_INIT,   1, 0);
        vecs[3]  = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_INIT,   1, 0);
        vecs[4]  = mk(0, 0, 1, PHY_DONE,   1, CMD_SEARCH, 1, 0);
        vecs[5]  = mk(0, 0, 1, PHY_IDLE,   0, CMD_SEARCH, 1, 0);
        vecs[6]  = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_SEARCH, 1, 0);
        vecs[7]  = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_SEARCH, 1, 0);
        vecs[8]  = mk(0, 0, 1, PHY_DONE,   1, CMD_LOCK,   1, 0);
        vecs[9]  = mk(0, 0, 1, PHY_IDLE,   0, CMD_LOCK,   1, 0);
        vecs[10] = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_LOCK,   1, 0);
        vecs[11] = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_LOCK,   1, 0);
        vecs[12] = mk(0, 0, 1, PHY_DONE,   0, CMD_LOCK,   0, 1);
        vecs[13] = mk(0, 0, 1, PHY_DONE,   0, CMD_LOCK,   0, 1);
        vecs[14] = mk(0, 1, 0, PHY_DONE,   1, CMD_UNLOCK, 1, 0);
        vecs[15] = mk(0, 0, 1, PHY_IDLE,   0, CMD_UNLOCK, 1, 0);
        vecs[16] = mk(0, 0, 1, PHY_ACTIVE, 0, CMD_UNLOCK, 1, 0);
        vecs[17] = mk(0, 0, 1, PHY_DONE,   0, CMD_UNLOCK, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].st, vecs[i].sp, vecs[i].rdy, vecs[i].ph);
            chk($sformatf("tbl%0d_valid", i),  o_cmd_valid, vecs[i].valid);
            chk($sformatf("tbl%0d_busy", i),   o_busy,      vecs[i].busy);
            chk($sformatf("tbl%0d_locked", i), o_locked,    vecs[i].locked);
            if (vecs[i].valid) chk($sformatf("tbl%0d_cmd", i), o_cmd, vecs[i].cmd);
        end
        chk("tbl_err",   o_err_code,  SEQ_ERR_NONE);
        chk("tbl_retry", o_retry_cnt, 0);

        // Backpressure: INIT held on offer for 5 stalled cycles, one transfer.
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_IDLE);
        base = xfers;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, PHY_IDLE);
            chk($sformatf("bp%0d_valid", i), o_cmd_valid, 1);
            chk($sformatf("bp%0d_cmd", i),   o_cmd,       CMD_INIT);
        end
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        chk("bp_after_valid", o_cmd_valid, 0);
        chk("bp_xfers", xfers - base, 1);

        // PHY error during SEARCH: one retry from INIT, lock still achieved.
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_IDLE);
        do_cmd("err_init", CMD_INIT);
        chk("err_srch_cmd", o_cmd, CMD_SEARCH);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        step(1'b0, 1'b0, 1'b1, PHY_ERROR);
        chk("err_retry1",  o_retry_cnt, 1);
        chk("err_code1",   o_err_code,  SEQ_ERR_PHY);
        do_cmd("err_r_init",   CMD_INIT);
        do_cmd("err_r_search", CMD_SEARCH);
        do_cmd("err_r_lock",   CMD_LOCK);
        chk("err_locked", o_locked,    1);
        chk("err_busy",   o_busy,      0);
        chk("err_code",   o_err_code,  SEQ_ERR_PHY);
        chk("err_retry",  o_retry_cnt, 1);

        // Timeout exhaustion: 3 attempts x (1 handshake + 16 wait cycles).
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_ACTIVE);
        steps = 0;
        while (!o_error && steps < 200) begin
            step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
            steps++;
        end
        chk("tmo_cycles", steps,       51);
        chk("tmo_error",  o_error,     1);
        chk("tmo_code",   o_err_code,  SEQ_ERR_TIMEOUT);
        chk("tmo_retry",  o_retry_cnt, 2);
        chk("tmo_busy",   o_busy,      0);
        step(1'b0, 1'b1, 1'b0, PHY_ACTIVE);
        chk("fail_stop_error", o_error,    0);
        chk("fail_stop_busy",  o_busy,     0);
        chk("fail_stop_code",  o_err_code, SEQ_ERR_TIMEOUT);
        step(1'b1, 1'b0, 1'b0, PHY_IDLE);
        chk("restart_valid", o_cmd_valid, 1);
        chk("restart_cmd",   o_cmd,       CMD_INIT);
        chk("restart_code",  o_err_code,  SEQ_ERR_NONE);
        chk("restart_retry", o_retry_cnt, 0);

        // Stale DONE held across the handshake must not advance the phase.
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_DONE);
        step(1'b0, 1'b0, 1'b1, PHY_DONE);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, PHY_DONE);
            chk($sformatf("stale%0d_valid", i), o_cmd_valid, 0);
            chk($sformatf("stale%0d_busy", i),  o_busy,      1);
        end
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        chk("stale_arm_valid", o_cmd_valid, 0);
        step(1'b0, 1'b0, 1'b1, PHY_DONE);
        chk("stale_adv_valid", o_cmd_valid, 1);
        chk("stale_adv_cmd",   o_cmd,       CMD_SEARCH);

        // Stop while a command is stalled: finish the handshake, then UNLOCK.
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_IDLE);
        step(1'b0, 1'b1, 1'b0, PHY_IDLE);
        chk("pend_hold_valid", o_cmd_valid, 1);
        chk("pend_hold_cmd",   o_cmd,       CMD_INIT);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        chk("pend_unl_valid", o_cmd_valid, 1);
        chk("pend_unl_cmd",   o_cmd,       CMD_UNLOCK);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        chk("pend_wait_valid", o_cmd_valid, 0);
        step(1'b0, 1'b0, 1'b1, PHY_ACTIVE);
        step(1'b0, 1'b0, 1'b1, PHY_DONE);
        chk("pend_idle_busy",   o_busy,   0);
        chk("pend_idle_locked", o_locked, 0);

        // Reset in SEQ_WAIT after a retry clears every output next cycle.
        do_reset();
        step(1'b1, 1'b0, 1'b0, PHY_IDLE);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        step(1'b0, 1'b0, 1'b1, PHY_ERROR);
        chk("rw_retry", o_retry_cnt, 1);
        chk("rw_code",  o_err_code,  SEQ_ERR_PHY);
        step(1'b0, 1'b0, 1'b1, PHY_IDLE);
        chk("rw_wait_valid", o_cmd_valid, 0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1, PHY_ACTIVE);
        rst = 1'b0;
        chk_reset_vals("rst_wait");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
